// File: rtl/dynamixel_sync_write_4bytes.sv
// Dynamixel 2.0 Sync Write generator: four servos, 4 data bytes each.
// Serialises one 34-byte 8N1 packet onto a half-duplex pin.
module dynamixel_sync_write_4bytes #(
    parameter int         clocks_per_bit = 3,
    parameter logic [7:0] id1            = 8'd1,
    parameter logic [7:0] id2            = 8'd2,
    parameter logic [7:0] id3            = 8'd3,
    parameter logic [7:0] id4            = 8'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] address,
    input  logic [31:0] value1,
    input  logic [31:0] value2,
    input  logic [31:0] value3,
    input  logic [31:0] value4,
    output logic        busy,
    inout  wire         pin
);

    localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(clocks_per_bit - 1);

    typedef enum logic {
        S_IDLE,
        S_TX
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [CW-1:0] r_cyc;
    logic [3:0]  r_bit;
    logic [5:0]  r_byte;
    logic [15:0] r_crc;
    logic [15:0] r_addr;
    logic [31:0] r_v1;
    logic [31:0] r_v2;
    logic [31:0] r_v3;
    logic [31:0] r_v4;
    logic        w_start;
    logic        w_bit_end;
    logic        w_byte_end;
    logic        w_pkt_end;
    logic [7:0]  w_byte;
    logic        w_tx;

    // Dynamixel CRC-16 (poly 0x8005, MSB first) advanced by one byte.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (x[15]) x = {x[14:0], 1'b0} ^ 16'h8005;
            else       x = {x[14:0], 1'b0};
        end
        return x;
    endfunction

    // Next-state logic and per-bit/per-byte/end-of-packet strobes.
    always_comb begin
        w_state_next = r_state;
        w_start      = (r_state == S_IDLE) && send && !reset;
        w_bit_end    = (r_state == S_TX) && (r_cyc == LAST_CYC);
        w_byte_end   = w_bit_end && (r_bit == 4'd9);
        w_pkt_end    = w_byte_end && (r_byte == 6'd33);
        unique case (r_state)
            S_IDLE: if (w_start) w_state_next = S_TX;
            S_TX:   if (w_pkt_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Snapshot of the packet payload taken when a send is accepted.
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_addr <= address;
            r_v1   <= value1;
            r_v2   <= value2;
            r_v3   <= value3;
            r_v4   <= value4;
        end
    end

    // Bit timing counters and running CRC over bytes 0..31.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cyc  <= '0;
            r_bit  <= '0;
            r_byte <= '0;
            r_crc  <= '0;
        end else if (w_start) begin
            r_cyc  <= '0;
            r_bit  <= '0;
            r_byte <= '0;
            r_crc  <= '0;
        end else if (r_state == S_TX) begin
            if (w_bit_end) begin
                r_cyc <= '0;
                if (w_byte_end) begin
                    r_bit  <= '0;
                    r_byte <= r_byte + 6'd1;
                    if (r_byte < 6'd32) r_crc <= crc_step(r_crc, w_byte);
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end
        end
    end

    // Byte mux over the fixed header, latched payload and final CRC.
    always_comb begin
        w_byte = 8'h00;
        unique case (r_byte)
            6'd0:  w_byte = 8'hFF;
            6'd1:  w_byte = 8'hFF;
            6'd2:  w_byte = 8'hFD;
            6'd3:  w_byte = 8'h00;
            6'd4:  w_byte = 8'hFE;
            6'd5:  w_byte = 8'h1B;
            6'd6:  w_byte = 8'h00;
            6'd7:  w_byte = 8'h83;
            6'd8:  w_byte = r_addr[7:0];
            6'd9:  w_byte = r_addr[15:8];
            6'd10: w_byte = 8'h04;
            6'd11: w_byte = 8'h00;
            6'd12: w_byte = id1;
            6'd13: w_byte = r_v1[7:0];
            6'd14: w_byte = r_v1[15:8];
            6'd15: w_byte = r_v1[23:16];
            6'd16: w_byte = r_v1[31:24];
            6'd17: w_byte = id2;
            6'd18: w_byte = r_v2[7:0];
            6'd19: w_byte = r_v2[15:8];
            6'd20: w_byte = r_v2[23:16];
            6'd21: w_byte = r_v2[31:24];
            6'd22: w_byte = id3;
            6'd23: w_byte = r_v3[7:0];
            6'd24: w_byte = r_v3[15:8];
            6'd25: w_byte = r_v3[23:16];
            6'd26: w_byte = r_v3[31:24];
            6'd27: w_byte = id4;
            6'd28: w_byte = r_v4[7:0];
            6'd29: w_byte = r_v4[15:8];
            6'd30: w_byte = r_v4[23:16];
            6'd31: w_byte = r_v4[31:24];
            6'd32: w_byte = r_crc[7:0];
            6'd33: w_byte = r_crc[15:8];
            default: w_byte = 8'h00;
        endcase
    end

    // 8N1 framing: bit 0 start, bits 1..8 data LSB first, bit 9 stop.
    always_comb begin
        w_tx = 1'b1;
        if (r_bit == 4'd0)      w_tx = 1'b0;
        else if (r_bit == 4'd9) w_tx = 1'b1;
        else                    w_tx = w_byte[3'(r_bit - 4'd1)];
    end

    assign busy = (r_state == S_TX);
    assign pin  = busy ? w_tx : 1'bz;

endmodule

// File: tb/tb_dynamixel_sync_write_4bytes.sv
// Bench for dynamixel_sync_write_4bytes: scoreboard of expected bytes
// against a bit-level receiver that also checks framing and timing.
module tb_dynamixel_sync_write_4bytes;

    localparam int CPB = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        send = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] value1 = '0;
    logic [31:0] value2 = '0;
    logic [31:0] value3 = '0;
    logic [31:0] value4 = '0;
    wire         busy;
    wire         pin;

    pullup (pin);

    dynamixel_sync_write_4bytes #(
        .clocks_per_bit(CPB),
        .id1(8'd1),
        .id2(8'd2),
        .id3(8'd3),
        .id4(8'd4)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .send(send),
        .address(address),
        .value1(value1),
        .value2(value2),
        .value3(value3),
        .value4(value4),
        .busy(busy),
        .pin(pin)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Table-driven form of the Dynamixel CRC; entries built on the fly.
    function automatic logic [15:0] crc_tbl(input logic [7:0] i);
        logic [15:0] r;
        r = {i, 8'h00};
        for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] c,
                                              input logic [7:0] d);
        return (c << 8) ^ crc_tbl(c[15:8] ^ d);
    endfunction

    task automatic push_pkt();
        logic [7:0]  p[34];
        logic [31:0] v[4];
        logic [15:0] c;
        v = '{value1, value2, value3, value4};
        p[0] = 8'hFF; p[1] = 8'hFF; p[2] = 8'hFD; p[3] = 8'h00;
        p[4] = 8'hFE; p[5] = 8'h1B; p[6] = 8'h00; p[7] = 8'h83;
        p[8] = address[7:0]; p[9] = address[15:8];
        p[10] = 8'h04; p[11] = 8'h00;
        for (int n = 0; n < 4; n++) begin
            p[12 + 5 * n] = 8'(n + 1);
            for (int m = 0; m < 4; m++)
                p[13 + 5 * n + m] = v[n][8 * m +: 8];
        end
        c = 16'h0000;
        for (int i = 0; i < 32; i++) c = crc_model(c, p[i]);
        p[32] = c[7:0];
        p[33] = c[15:8];
        for (int i = 0; i < 34; i++) q.push_back(p[i]);
    endtask

    // Called on a negedge; leaves at the first start-bit cycle.
    task automatic send_pkt();
        send = 1'b1;
        push_pkt();
        @(negedge clock);
        send = 1'b0;
    endtask

    // act: 1 change value1, 2 pulse send, 3 reset; at byte act_byte.
    task automatic rx_pkt(input int act_byte, input int act);
        int         nb;
        logic [9:0] bits;
        logic       bad;
        logic [7:0] exp;
        nb = 0;
        for (int b = 0; b < 34; b++) begin
            bad = 1'b0;
            bits = '0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (b == act_byte && k == 0 && c == 0) begin
                        if (act == 1) value1 = 32'h11223344;
                        if (act == 2) send = 1'b1;
                        if (act == 3) begin
                            reset = 1'b1;
                            @(negedge clock);
                            reset = 1'b0;
                            chk("abort_busy", 32'(busy), 0);
                            chk("abort_pin", 32'(pin), 1);
                            q.delete();
                            return;
                        end
                    end
                    if (c == 0) bits[k] = pin;
                    else if (pin !== bits[k]) bad = 1'b1;
                    if (busy) nb++;
                    @(negedge clock);
                    send = 1'b0;
                end
            end
            exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
            chk($sformatf("start%0d", b), 32'(bits[0]), 0);
            chk($sformatf("stop%0d", b), 32'(bits[9]), 1);
            chk($sformatf("bitw%0d", b), 32'(bad), 0);
            chk($sformatf("byte%0d", b), 32'(bits[8:1]), 32'(exp));
        end
        chk("end_busy", 32'(busy), 0);
        chk("end_pin", 32'(pin), 1);
        chk("busy_len", nb, 340 * CPB);
    endtask

    initial begin
        logic bad;
        repeat (5) @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pin", 32'(pin), 1);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pin", 32'(pin), 1);

        address = 16'h0074;
        value1 = 32'd0;
        value2 = 32'd256;
        value3 = 32'd256;
        value4 = 32'd0;
        send_pkt();
        rx_pkt(-1, 0);

        repeat (2) begin
            repeat (2001 - 1021) @(negedge clock);
            send_pkt();
            rx_pkt(-1, 0);
        end

        repeat (10) @(negedge clock);
        send_pkt();
        rx_pkt(15, 1);
        repeat (10) @(negedge clock);
        send_pkt();
        rx_pkt(-1, 0);

        repeat (10) @(negedge clock);
        send_pkt();
        rx_pkt(10, 2);
        repeat (5) @(negedge clock);
        chk("no_queue", 32'(busy), 0);

        repeat (10) @(negedge clock);
        send_pkt();
        rx_pkt(20, 3);
        bad = 1'b0;
        repeat (20) begin
            if (busy !== 1'b0 || pin !== 1'b1) bad = 1'b1;
            @(negedge clock);
        end
        chk("post_abort_quiet", 32'(bad), 0);
        send_pkt();
        rx_pkt(-1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
